// File: rtl/poc_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : poc_fifo_ctrl_if
// Description : Bus and printer-port bundle for poc_fifo_ctrl.
//               CPU side : i_cs, i_rw, i_addr, i_din -> o_dout, o_irq
//               Printer  : i_rdy -> o_tr, o_pd
//               slave  modport = controller view, master = bus/printer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface poc_fifo_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              i_cs;
  logic              i_rw;
  logic              i_addr;
  logic [DATA_W-1:0] i_din;
  logic [DATA_W-1:0] o_dout;
  logic              o_irq;
  logic              i_rdy;
  logic              o_tr;
  logic [DATA_W-1:0] o_pd;

  modport slave (
    input  i_cs, i_rw, i_addr, i_din, i_rdy,
    output o_dout, o_irq, o_tr, o_pd
  );

  modport master (
    output i_cs, i_rw, i_addr, i_din, i_rdy,
    input  o_dout, o_irq, o_tr, o_pd
  );
endinterface
`default_nettype wire

// File: rtl/poc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : poc_fifo_ctrl
// Description : Buffered parallel printer controller. The CPU pushes words
//               into a DEPTH-entry FIFO; a RDY/TR handshake engine drains
//               them to the printer one word per handshake.
// Ports       : i_clk   - clock
//               i_rst_n - asynchronous active-low reset
//               bus     - poc_fifo_ctrl_if.slave (CPU bus + printer port)
// Revision    : 1.0 - initial release
// ============================================================================
module poc_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int LOW_WM    = 1,
  parameter int TR_CYCLES = 1
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  poc_fifo_ctrl_if.slave     bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TRC_W = (TR_CYCLES > 1) ? $clog2(TR_CYCLES) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_STROBE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  // Storage and state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] pd_q;
  logic              tr_q, tr_d;
  logic              ie_q, ovf_q;
  logic              rdy_meta_q, rdy_s_q;
  logic [1:0]        state_q, state_d;
  logic [TRC_W-1:0]  trcnt_q, trcnt_d;

  // Bus decode
  logic wr_acc, full, empty, push, pop, ovf_set, stat_wr;
  logic [DATA_W-1:0] status;

  assign wr_acc  = bus.i_cs & bus.i_rw;
  assign stat_wr = wr_acc & ~bus.i_addr;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is taken from the registered count, so a push on a full FIFO is
  // rejected even if the engine frees a slot on the same edge.
  assign push    = wr_acc & bus.i_addr & ~full;
  assign ovf_set = wr_acc & bus.i_addr & full;
  assign pop     = (state_q == S_IDLE) & ~empty & rdy_s_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload: no reset needed, contents are only meaningful via count.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pd_q       <= '0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
    end else begin
      rdy_meta_q <= bus.i_rdy;
      rdy_s_q    <= rdy_meta_q;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        pd_q     <= mem_q[rd_ptr_q];
      end
      if (stat_wr) ie_q <= bus.i_din[0];
      // Overflow set has priority over a simultaneous write-1-to-clear.
      if (ovf_set)                     ovf_q <= 1'b1;
      else if (stat_wr && bus.i_din[5]) ovf_q <= 1'b0;
    end
  end

  // Engine FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      trcnt_q <= '0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trcnt_q <= trcnt_d;
      tr_q    <= tr_d;
    end
  end

  // Engine FSM: next state
  always_comb begin
    state_d = state_q;
    trcnt_d = trcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_STROBE;
          trcnt_d = '0;
        end
      end
      S_STROBE: begin
        if (trcnt_q == TRC_W'(TR_CYCLES - 1)) state_d = S_WAIT_ACK;
        else                                  trcnt_d = trcnt_q + TRC_W'(1);
      end
      S_WAIT_ACK:  if (!rdy_s_q) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (rdy_s_q)  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Engine FSM: outputs. The strobe is registered from the next state so it
  // is high for exactly the cycles spent in STROBE.
  always_comb begin
    tr_d = (state_d == S_STROBE);
  end

  // Status word and read mux
  always_comb begin
    status    = '0;
    status[7] = ~full;
    status[6] = empty;
    status[5] = ovf_q;
    status[4] = (state_q != S_IDLE);
    status[0] = ie_q;
  end

  always_comb begin
    bus.o_dout = '0;
    if (bus.i_cs && !bus.i_rw) begin
      bus.o_dout = bus.i_addr ? DATA_W'(count_q) : status;
    end
  end

  assign bus.o_irq = ~(ie_q & (count_q <= CNT_W'(LOW_WM)));
  assign bus.o_tr  = tr_q;
  assign bus.o_pd  = pd_q;

endmodule
`default_nettype wire

// File: tb/tb_poc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_poc_fifo_ctrl
// Description : Self-checking bench for poc_fifo_ctrl. A printer model pops
//               expected words from a scoreboard queue on each o_tr pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poc_fifo_ctrl;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int LOW_WM    = 1;
  localparam int TR_CYCLES = 3;

  logic clk;
  logic rst_n;

  poc_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  poc_fifo_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .LOW_WM   (LOW_WM),
    .TR_CYCLES(TR_CYCLES)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_printed = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Printer model: rdy drops for 5 cycles after each strobe.
  logic prn_hold;
  logic prn_busy;
  int   busy_cnt;
  int   tr_len;
  logic tr_prev;
  assign bus.i_rdy = ~prn_hold & ~prn_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      tr_prev  = 1'b0;
      tr_len   = 0;
      prn_busy = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) prn_busy = 1'b0;
      end
      if (bus.o_tr && !tr_prev) begin
        n_printed++;
        check_eq("print_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("print_data", bus.o_pd, exp_q.pop_front());
      end
      if (bus.o_tr) tr_len++;
      if (!bus.o_tr && tr_prev) begin
        check_eq("tr_width", tr_len, TR_CYCLES);
        tr_len   = 0;
        prn_busy = 1'b1;
        busy_cnt = 5;
      end
      tr_prev = bus.o_tr;
    end
  end

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.i_cs = 1'b1; bus.i_rw = 1'b1; bus.i_addr = a; bus.i_din = d;
    @(posedge clk); #1;
    bus.i_cs = 1'b0; bus.i_rw = 1'b0; bus.i_din = '0;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    bus.i_cs = 1'b1; bus.i_rw = 1'b0; bus.i_addr = a;
    #1;
    d = bus.o_dout;
    bus.i_cs = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d);
    exp_q.push_back(d);
    cpu_write(1'b1, d);
  endtask

  task automatic printer_off();
    prn_hold = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input logic [7:0] exp_st);
    logic [7:0] st;
    st = '0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      cpu_read(1'b0, st);
      if (st == exp_st && exp_q.size() == 0) break;
    end
    check_eq("idle_status", st, exp_st);
    check_eq("idle_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st, cnt;
    logic       irq_at2, seen;
    int         printed0;

    rst_n = 1'b0;
    prn_hold = 1'b1;
    bus.i_cs = 1'b0; bus.i_rw = 1'b0; bus.i_addr = 1'b0; bus.i_din = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    cpu_read(1'b0, st);  check_eq("rst_status", st, 8'hC0);
    cpu_read(1'b1, cnt); check_eq("rst_count", cnt, 0);
    check_eq("rst_irq", bus.o_irq, 1);
    check_eq("rst_tr", bus.o_tr, 0);
    check_eq("rst_pd", bus.o_pd, 0);

    // Polling: fill with printer held off, then drain in order
    printer_off();
    printed0 = n_printed;
    for (int i = 0; i < 4; i++) push_word(8'h41 + 8'(i));
    cpu_read(1'b0, st);  check_eq("poll_full_status", st, 8'h00);
    cpu_read(1'b1, cnt); check_eq("poll_full_count", cnt, 4);
    prn_hold = 1'b0;
    wait_idle(8'hC0);
    check_eq("poll_printed", n_printed - printed0, 4);

    // Overflow and write-1-to-clear
    printer_off();
    for (int i = 0; i < 4; i++) push_word(8'h61 + 8'(i));
    cpu_write(1'b1, 8'h55);
    cpu_read(1'b1, cnt); check_eq("ovf_count", cnt, 4);
    cpu_read(1'b0, st);  check_eq("ovf_status", st, 8'h20);
    cpu_write(1'b0, 8'h20);
    cpu_read(1'b0, st);  check_eq("ovf_cleared", st, 8'h00);
    prn_hold = 1'b0;
    wait_idle(8'hC0);

    // Interrupt mode with low watermark
    cpu_write(1'b0, 8'h01);
    check_eq("irq_empty_low", bus.o_irq, 0);
    printer_off();
    for (int i = 0; i < 4; i++) push_word(8'h71 + 8'(i));
    check_eq("irq_full_high", bus.o_irq, 1);
    cpu_read(1'b0, st); check_eq("irq_full_status", st, 8'h01);
    prn_hold = 1'b0;
    irq_at2 = 1'b0; seen = 1'b0; cnt = '0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      cpu_read(1'b1, cnt);
      if (cnt == 2) irq_at2 = bus.o_irq;
      if (cnt == 1) begin seen = 1'b1; break; end
    end
    check_eq("irq_count1_seen", seen, 1);
    check_eq("irq_at_count2", irq_at2, 1);
    check_eq("irq_at_count1", bus.o_irq, 0);
    wait_idle(8'hC1);
    cpu_write(1'b0, 8'h00);
    check_eq("irq_ie_off", bus.o_irq, 1);

    // Strobe latency: one word queued, rdy rises just after edge N
    printer_off();
    push_word(8'h5A);
    prn_hold = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("lat_tr_N+%0d", k), bus.o_tr, (k >= 3 && k < 3 + TR_CYCLES) ? 1 : 0);
      if (k == 3) check_eq("lat_pd", bus.o_pd, 8'h5A);
    end
    wait_idle(8'hC0);

    // Push and pop on the same edge with count = 2
    printer_off();
    push_word(8'hA1);
    push_word(8'hA2);
    prn_hold = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    exp_q.push_back(8'hA3);
    bus.i_cs = 1'b1; bus.i_rw = 1'b1; bus.i_addr = 1'b1; bus.i_din = 8'hA3;
    @(posedge clk); #1;
    bus.i_cs = 1'b0; bus.i_rw = 1'b0;
    cpu_read(1'b1, cnt); check_eq("pp_count", cnt, 2);
    check_eq("pp_tr", bus.o_tr, 1);
    check_eq("pp_pd", bus.o_pd, 8'hA1);
    wait_idle(8'hC0);

    // Push on full with a same-edge pop is rejected
    printer_off();
    for (int i = 0; i < 4; i++) push_word(8'hB1 + 8'(i));
    prn_hold = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.i_cs = 1'b1; bus.i_rw = 1'b1; bus.i_addr = 1'b1; bus.i_din = 8'h99;
    @(posedge clk); #1;
    bus.i_cs = 1'b0; bus.i_rw = 1'b0;
    cpu_read(1'b1, cnt); check_eq("fp_count", cnt, 3);
    cpu_read(1'b0, st);  check_eq("fp_status", st, 8'hB0);
    cpu_write(1'b0, 8'h20);
    cpu_read(1'b0, st);  check_eq("fp_ovf_clr", st[5], 0);
    wait_idle(8'hC0);

    // Asynchronous reset in the middle of a strobe
    printer_off();
    printed0 = n_printed;
    push_word(8'hE1);
    cpu_write(1'b1, 8'hE2);
    prn_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.o_tr) begin seen = 1'b1; break; end
    end
    check_eq("rstmid_tr_seen", seen, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_tr_async", bus.o_tr, 0);
    check_eq("rstmid_pd", bus.o_pd, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_read(1'b0, st);  check_eq("rstmid_status", st, 8'hC0);
    cpu_read(1'b1, cnt); check_eq("rstmid_count", cnt, 0);
    check_eq("rstmid_irq", bus.o_irq, 1);
    repeat (40) @(posedge clk);
    #1;
    check_eq("rstmid_printed", n_printed - printed0, 1);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
